// File: rtl/alu_exec.sv
// alu_exec: RV32I integer execution unit on the reservation-station dispatch
// port. Takes one ready operation per cycle, computes the rd value and, for
// control-flow ops, the branch decision and target, then drives the common
// result broadcast (ALU_valid / ALU_value / ALU_robid) seen by RS, ROB and LSB.
//
// Optional feature macro: ALU_ITER_SHIFT_EN
//   defined   - shifts with a nonzero amount go through a bit-serial shift
//               FSM (IDLE -> SHIFT -> DONE), latency 1+shamt, ALU_busy
//               back-pressures the RS while it runs.
//   undefined - single-cycle barrel shifter, every op 1 cycle, ALU_busy = 0.
//
// Handshake: the RS presents an op with ALU_enable; it is taken on a rising
// edge where rdy && ALU_enable && !ALU_busy && !pred_fail_flag. Anything
// presented while busy or during a flush is simply not taken. A result is
// broadcast for exactly one rdy-cycle with ALU_valid high; there is no
// downstream back-pressure. rdy low freezes every register.

`ifndef OP_SIZE_LOG
`define OP_SIZE_LOG 6
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4
`endif

module alu_exec (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     pred_fail_flag,
    input  logic                     ALU_enable,
    input  logic [`OP_SIZE_LOG-1:0]  op_to_ALU,
    input  logic [31:0]              vj_to_ALU,
    input  logic [31:0]              vk_to_ALU,
    input  logic [31:0]              imm_to_ALU,
    input  logic [`ROB_SIZE_LOG-1:0] robid_to_ALU,
    input  logic [31:0]              curpc_to_ALU,
    output logic                     ALU_valid,
    output logic [31:0]              ALU_value,
    output logic [`ROB_SIZE_LOG-1:0] ALU_robid,
    output logic                     ALU_jump,
    output logic [31:0]              ALU_target_pc,
    output logic                     ALU_busy
);

    localparam int OPW = `OP_SIZE_LOG;

    // Operation encodings shared with the decoder / RS.
    localparam logic [OPW-1:0] OP_LUI   = OPW'(1);
    localparam logic [OPW-1:0] OP_AUIPC = OPW'(2);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(3);
    localparam logic [OPW-1:0] OP_JALR  = OPW'(4);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(7);
    localparam logic [OPW-1:0] OP_BGE   = OPW'(8);
    localparam logic [OPW-1:0] OP_BLTU  = OPW'(9);
    localparam logic [OPW-1:0] OP_BGEU  = OPW'(10);
    // 11..15 loads, 16..18 stores: never produce a broadcast here.
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(19);
    localparam logic [OPW-1:0] OP_SLTI  = OPW'(20);
    localparam logic [OPW-1:0] OP_SLTIU = OPW'(21);
    localparam logic [OPW-1:0] OP_XORI  = OPW'(22);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(23);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(24);
    localparam logic [OPW-1:0] OP_SLLI  = OPW'(25);
    localparam logic [OPW-1:0] OP_SRLI  = OPW'(26);
    localparam logic [OPW-1:0] OP_SRAI  = OPW'(27);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(28);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(29);
    localparam logic [OPW-1:0] OP_SLL   = OPW'(30);
    localparam logic [OPW-1:0] OP_SLT   = OPW'(31);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'(32);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(33);
    localparam logic [OPW-1:0] OP_SRL   = OPW'(34);
    localparam logic [OPW-1:0] OP_SRA   = OPW'(35);
    localparam logic [OPW-1:0] OP_OR    = OPW'(36);
    localparam logic [OPW-1:0] OP_AND   = OPW'(37);

    // Shift flavours.
    localparam logic [1:0] SK_LL = 2'd0;   // logical left
    localparam logic [1:0] SK_RL = 2'd1;   // logical right
    localparam logic [1:0] SK_RA = 2'd2;   // arithmetic right

    // ------------------------------------------------------------------
    // Operand views and shared adders/comparators
    // ------------------------------------------------------------------
    logic signed [31:0] vj_s, vk_s, imm_s;
    logic        [31:0] pc_plus4, pc_plus_imm, jalr_sum;
    logic               eq_jk, lt_s_jk, lt_u_jk;

    assign vj_s        = vj_to_ALU;
    assign vk_s        = vk_to_ALU;
    assign imm_s       = imm_to_ALU;
    assign pc_plus4    = curpc_to_ALU + 32'd4;
    assign pc_plus_imm = curpc_to_ALU + imm_to_ALU;
    assign jalr_sum    = vj_to_ALU + imm_to_ALU;
    assign eq_jk       = (vj_to_ALU == vk_to_ALU);
    assign lt_s_jk     = (vj_s < vk_s);
    assign lt_u_jk     = (vj_to_ALU < vk_to_ALU);

    // ------------------------------------------------------------------
    // Single-cycle result for the op currently on the dispatch port
    // ------------------------------------------------------------------
    logic        res_valid;
    logic [31:0] res_value;
    logic        res_jump;
    logic [31:0] res_target;
    logic        is_branch;
    logic        br_taken;
    logic        shift_op;
    logic [1:0]  shift_kind;
    logic [4:0]  shift_amt;

    // Decode the op and compute value, jump decision and target.
    always_comb begin
        res_valid  = 1'b1;
        res_value  = 32'd0;
        res_jump   = 1'b0;
        res_target = pc_plus4;
        is_branch  = 1'b0;
        br_taken   = 1'b0;
        shift_op   = 1'b0;
        shift_kind = SK_LL;
        shift_amt  = vk_to_ALU[4:0];
        case (op_to_ALU)
            OP_LUI:   res_value = imm_to_ALU;
            OP_AUIPC: res_value = pc_plus_imm;
            OP_ADD:   res_value = vj_to_ALU + vk_to_ALU;
            OP_ADDI:  res_value = jalr_sum;
            OP_SUB:   res_value = vj_to_ALU - vk_to_ALU;
            OP_SLT:   res_value = {31'd0, lt_s_jk};
            OP_SLTI:  res_value = {31'd0, (vj_s < imm_s)};
            OP_SLTU:  res_value = {31'd0, lt_u_jk};
            OP_SLTIU: res_value = {31'd0, (vj_to_ALU < imm_to_ALU)};
            OP_XOR:   res_value = vj_to_ALU ^ vk_to_ALU;
            OP_XORI:  res_value = vj_to_ALU ^ imm_to_ALU;
            OP_OR:    res_value = vj_to_ALU | vk_to_ALU;
            OP_ORI:   res_value = vj_to_ALU | imm_to_ALU;
            OP_AND:   res_value = vj_to_ALU & vk_to_ALU;
            OP_ANDI:  res_value = vj_to_ALU & imm_to_ALU;
            OP_SLL:   begin shift_op = 1'b1; shift_kind = SK_LL; shift_amt = vk_to_ALU[4:0];  end
            OP_SLLI:  begin shift_op = 1'b1; shift_kind = SK_LL; shift_amt = imm_to_ALU[4:0]; end
            OP_SRL:   begin shift_op = 1'b1; shift_kind = SK_RL; shift_amt = vk_to_ALU[4:0];  end
            OP_SRLI:  begin shift_op = 1'b1; shift_kind = SK_RL; shift_amt = imm_to_ALU[4:0]; end
            OP_SRA:   begin shift_op = 1'b1; shift_kind = SK_RA; shift_amt = vk_to_ALU[4:0];  end
            OP_SRAI:  begin shift_op = 1'b1; shift_kind = SK_RA; shift_amt = imm_to_ALU[4:0]; end
            OP_JAL: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = pc_plus_imm;
            end
            OP_JALR: begin
                res_value  = pc_plus4;
                res_jump   = 1'b1;
                res_target = {jalr_sum[31:1], 1'b0};
            end
            OP_BEQ:  begin is_branch = 1'b1; br_taken = eq_jk;    end
            OP_BNE:  begin is_branch = 1'b1; br_taken = !eq_jk;   end
            OP_BLT:  begin is_branch = 1'b1; br_taken = lt_s_jk;  end
            OP_BGE:  begin is_branch = 1'b1; br_taken = !lt_s_jk; end
            OP_BLTU: begin is_branch = 1'b1; br_taken = lt_u_jk;  end
            OP_BGEU: begin is_branch = 1'b1; br_taken = !lt_u_jk; end
            default: res_valid = 1'b0;    // loads, stores, unknown: dropped
        endcase

        // Branches write no register; only the decision and target matter.
        if (is_branch) begin
            res_value  = 32'd0;
            res_jump   = br_taken;
            res_target = br_taken ? pc_plus_imm : pc_plus4;
        end

        if (shift_op) begin
`ifdef ALU_ITER_SHIFT_EN
            // Only a zero-amount shift finishes here; others go bit-serial.
            res_value = vj_to_ALU;
`else
            case (shift_kind)
                SK_LL:   res_value = vj_to_ALU << shift_amt;
                SK_RL:   res_value = vj_to_ALU >> shift_amt;
                default: res_value = vj_s >>> shift_amt;
            endcase
`endif
        end
    end

    logic accept;
    logic start_iter;   // accepted shift that must run through the FSM
    logic shift_done;   // FSM is presenting a finished shift this cycle

    assign accept = rdy && ALU_enable && !ALU_busy && !pred_fail_flag;

`ifdef ALU_ITER_SHIFT_EN
    // ------------------------------------------------------------------
    // Bit-serial shift FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    shift_state_t shift_state, shift_state_nxt;
    logic         shift_step;

    logic [31:0]              sh_val;
    logic [4:0]               sh_cnt;
    logic [1:0]               sh_kind;
    logic [`ROB_SIZE_LOG-1:0] sh_robid;
    logic [31:0]              sh_pc4;

    assign start_iter = accept && shift_op && (shift_amt != 5'd0);

    // State register: flush or reset abandon any shift in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_state <= S_IDLE;
        end else if (rdy) begin
            if (pred_fail_flag) shift_state <= S_IDLE;
            else                shift_state <= shift_state_nxt;
        end
    end

    // Next state: SHIFT runs until the last bit moves, DONE lasts one cycle.
    always_comb begin
        shift_state_nxt = shift_state;
        case (shift_state)
            S_IDLE:  if (start_iter)      shift_state_nxt = S_SHIFT;
            S_SHIFT: if (sh_cnt == 5'd1)  shift_state_nxt = S_DONE;
            S_DONE:                       shift_state_nxt = S_IDLE;
            default:                      shift_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: busy whenever a shift owns the unit.
    always_comb begin
        ALU_busy   = (shift_state != S_IDLE);
        shift_step = (shift_state == S_SHIFT);
        shift_done = (shift_state == S_DONE);
    end

    // Shift datapath: load on accept, then move one bit per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_val   <= 32'd0;
            sh_cnt   <= 5'd0;
            sh_kind  <= SK_LL;
            sh_robid <= '0;
            sh_pc4   <= 32'd0;
        end else if (rdy) begin
            if (start_iter) begin
                sh_val   <= vj_to_ALU;
                sh_cnt   <= shift_amt;
                sh_kind  <= shift_kind;
                sh_robid <= robid_to_ALU;
                sh_pc4   <= pc_plus4;
            end else if (shift_step) begin
                sh_cnt <= sh_cnt - 5'd1;
                case (sh_kind)
                    SK_LL:   sh_val <= {sh_val[30:0], 1'b0};
                    SK_RL:   sh_val <= {1'b0, sh_val[31:1]};
                    default: sh_val <= {sh_val[31], sh_val[31:1]};
                endcase
            end
        end
    end
`else
    assign ALU_busy   = 1'b0;
    assign start_iter = 1'b0;
    assign shift_done = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Result broadcast register
    // ------------------------------------------------------------------
    // Registers the broadcast; a valid lasts one rdy-cycle, flush wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_valid     <= 1'b0;
            ALU_value     <= 32'd0;
            ALU_robid     <= '0;
            ALU_jump      <= 1'b0;
            ALU_target_pc <= 32'd0;
        end else if (rdy) begin
            if (pred_fail_flag) begin
                ALU_valid <= 1'b0;
                ALU_jump  <= 1'b0;
`ifdef ALU_ITER_SHIFT_EN
            end else if (shift_done) begin
                ALU_valid     <= 1'b1;
                ALU_value     <= sh_val;
                ALU_robid     <= sh_robid;
                ALU_jump      <= 1'b0;
                ALU_target_pc <= sh_pc4;
`endif
            end else if (accept && res_valid && !start_iter) begin
                ALU_valid     <= 1'b1;
                ALU_value     <= res_value;
                ALU_robid     <= robid_to_ALU;
                ALU_jump      <= res_jump;
                ALU_target_pc <= res_target;
            end else begin
                ALU_valid <= 1'b0;
            end
        end
    end

    // Keeps the shift-done path referenced in builds without the FSM.
    logic unused_ok;
    assign unused_ok = shift_done;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases from the design notes,
// randomized dispatch streams against a behavioural model, flush, rdy hold,
// async reset and (when ALU_ITER_SHIFT_EN is defined) the bit-serial shifter.

module tb_alu_exec;

    localparam logic [5:0] OP_LUI = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL = 6'd3,  OP_JALR = 6'd4;
    localparam logic [5:0] OP_BEQ = 6'd5,  OP_BNE = 6'd6,  OP_BLT = 6'd7,  OP_BGE = 6'd8;
    localparam logic [5:0] OP_BLTU = 6'd9, OP_BGEU = 6'd10, OP_LW = 6'd13, OP_SW = 6'd18;
    localparam logic [5:0] OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22;
    localparam logic [5:0] OP_ORI = 6'd23, OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26;
    localparam logic [5:0] OP_SRAI = 6'd27, OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30;
    localparam logic [5:0] OP_SLT = 6'd31, OP_SLTU = 6'd32, OP_XOR = 6'd33, OP_SRL = 6'd34;
    localparam logic [5:0] OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

    typedef struct packed {
        logic        valid;
        logic [31:0] value;
        logic [3:0]  robid;
        logic        jump;
        logic [31:0] target;
    } res_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst, rdy, pred_fail_flag, ALU_enable;
    logic [5:0]  op_to_ALU;
    logic [31:0] vj_to_ALU, vk_to_ALU, imm_to_ALU, curpc_to_ALU;
    logic [3:0]  robid_to_ALU;
    logic        ALU_valid, ALU_jump, ALU_busy;
    logic [31:0] ALU_value, ALU_target_pc;
    logic [3:0]  ALU_robid;

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pred_fail_flag(pred_fail_flag),
        .ALU_enable(ALU_enable), .op_to_ALU(op_to_ALU), .vj_to_ALU(vj_to_ALU),
        .vk_to_ALU(vk_to_ALU), .imm_to_ALU(imm_to_ALU), .robid_to_ALU(robid_to_ALU),
        .curpc_to_ALU(curpc_to_ALU), .ALU_valid(ALU_valid), .ALU_value(ALU_value),
        .ALU_robid(ALU_robid), .ALU_jump(ALU_jump), .ALU_target_pc(ALU_target_pc),
        .ALU_busy(ALU_busy)
    );

    int n_vec = 0;
    int n_err = 0;
    res_t exp_q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic is_shift(input logic [5:0] op);
        return (op == OP_SLL) || (op == OP_SLLI) || (op == OP_SRL) || (op == OP_SRLI) ||
               (op == OP_SRA) || (op == OP_SRAI);
    endfunction

    // Architectural result of one RV32I op; valid=0 means no broadcast.
    function automatic res_t model(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                                   input logic [3:0] rob);
        res_t r;
        logic [63:0] ext;
        int sa;
        logic take;
        r = '0;
        r.valid = 1'b1;
        r.robid = rob;
        r.target = pc + 32'd4;
        take = 1'b0;
        sa = (op == OP_SLLI || op == OP_SRLI || op == OP_SRAI) ? int'(imm % 32) : int'(b % 32);
        case (op)
            OP_LUI:   r.value = imm;
            OP_AUIPC: r.value = pc + imm;
            OP_ADD:   r.value = a + b;
            OP_ADDI:  r.value = a + imm;
            OP_SUB:   r.value = a - b;
            OP_SLT:   r.value = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTI:  r.value = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            OP_SLTU:  r.value = (a < b) ? 32'd1 : 32'd0;
            OP_SLTIU: r.value = (a < imm) ? 32'd1 : 32'd0;
            OP_XOR:   r.value = a ^ b;
            OP_XORI:  r.value = a ^ imm;
            OP_OR:    r.value = a | b;
            OP_ORI:   r.value = a | imm;
            OP_AND:   r.value = a & b;
            OP_ANDI:  r.value = a & imm;
            OP_SLL, OP_SLLI: r.value = a << sa;
            OP_SRL, OP_SRLI: r.value = a >> sa;
            OP_SRA, OP_SRAI: begin
                ext = {{32{a[31]}}, a} >> sa;
                r.value = ext[31:0];
            end
            OP_JAL:  begin r.value = pc + 32'd4; r.jump = 1'b1; r.target = pc + imm; end
            OP_JALR: begin r.value = pc + 32'd4; r.jump = 1'b1; r.target = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  take = (a == b);
                    OP_BNE:  take = (a != b);
                    OP_BLT:  take = ($signed(a) < $signed(b));
                    OP_BGE:  take = ($signed(a) >= $signed(b));
                    OP_BLTU: take = (a < b);
                    default: take = (a >= b);
                endcase
                r.value = 32'd0;
                r.jump = take;
                r.target = take ? pc + imm : pc + 32'd4;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic res_t sample();
        res_t s;
        s.valid = ALU_valid; s.value = ALU_value; s.robid = ALU_robid;
        s.jump = ALU_jump; s.target = ALU_target_pc;
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                         input logic [3:0] rob);
        ALU_enable = 1'b1; op_to_ALU = op; vj_to_ALU = a; vk_to_ALU = b;
        imm_to_ALU = imm; curpc_to_ALU = pc; robid_to_ALU = rob;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        res_t o;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(6'($urandom_range(1, 37)), $urandom, $urandom, $urandom, $urandom, 4'($urandom));
            step();
        end
        ALU_enable = 1'b0;
        o = sample();
        n_vec++;
        if (o !== res_t'(0)) begin n_err++; $display("FAIL reset_outputs: got %h want 0", o); end
        n_vec++;
        if (ALU_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ALU_busy); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        res_t o;
        res_t e;
        drive(OP_SUB, 32'd0, 32'd1, 32'd0, 32'h200, 4'd5); step(); ALU_enable = 1'b0;
        o = sample(); e = '{1'b1, 32'hFFFF_FFFF, 4'd5, 1'b0, 32'h204}; n_vec++;
        if (o !== e) begin n_err++; $display("FAIL sub_wrap: got %h want %h", o, e); end

        drive(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd3); step(); ALU_enable = 1'b0;
        o = sample(); e = '{1'b1, 32'd0, 4'd3, 1'b1, 32'h120}; n_vec++;
        if (o !== e) begin n_err++; $display("FAIL blt_signed: got %h want %h", o, e); end

        drive(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd3); step(); ALU_enable = 1'b0;
        o = sample(); e = '{1'b1, 32'd0, 4'd3, 1'b0, 32'h104}; n_vec++;
        if (o !== e) begin n_err++; $display("FAIL bltu_unsigned: got %h want %h", o, e); end

        drive(OP_JALR, 32'h1003, 32'd0, 32'd0, 32'h40, 4'd7); step(); ALU_enable = 1'b0;
        o = sample(); e = '{1'b1, 32'h44, 4'd7, 1'b1, 32'h1002}; n_vec++;
        if (o !== e) begin n_err++; $display("FAIL jalr_lsb: got %h want %h", o, e); end

        drive(OP_LW, 32'h10, 32'd0, 32'd4, 32'h50, 4'd2); step(); ALU_enable = 1'b0;
        n_vec++;
        if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL load_dropped: got valid %b want 0", ALU_valid); end

        drive(OP_SW, 32'h10, 32'd9, 32'd4, 32'h54, 4'd2); step(); ALU_enable = 1'b0;
        n_vec++;
        if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL store_dropped: got valid %b want 0", ALU_valid); end
    endtask

    // Back-to-back random dispatch stream through the scoreboard.
    task automatic test_random(input int n);
        res_t o;
        res_t e;
        logic [5:0] op;
        logic [31:0] a, b, imm;
        for (int i = 0; i < n; i++) begin
            op = 6'($urandom_range(0, 40));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
`ifdef ALU_ITER_SHIFT_EN
            if (is_shift(op)) begin b[4:0] = 5'd0; imm[4:0] = 5'd0; end
`endif
            drive(op, a, b, imm, $urandom & 32'hFFFF_FFFC, 4'($urandom));
            ALU_enable = ($urandom_range(0, 4) != 0);
            if (ALU_enable) exp_q.push_back(model(op, a, b, imm, curpc_to_ALU, robid_to_ALU));
            else            exp_q.push_back(res_t'(0));
            step();
            e = exp_q.pop_front();
            o = sample();
            n_vec++;
            if (e.valid) begin
                if (o !== e) begin n_err++; $display("FAIL random_op%0d: got %h want %h", op, o, e); end
            end else if (o.valid !== 1'b0) begin
                n_err++; $display("FAIL random_novalid_op%0d: got valid %b want 0", op, o.valid);
            end
        end
        ALU_enable = 1'b0;
    endtask

    task automatic test_flush();
        drive(OP_JAL, 32'd0, 32'd0, 32'h80, 32'h300, 4'd4); step();
        n_vec++;
        if (ALU_valid !== 1'b1 || ALU_jump !== 1'b1) begin
            n_err++; $display("FAIL flush_setup: got valid %b jump %b want 1 1", ALU_valid, ALU_jump);
        end
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h304, 4'd8);
        pred_fail_flag = 1'b1; step(); pred_fail_flag = 1'b0; ALU_enable = 1'b0;
        n_vec++;
        if (ALU_valid !== 1'b0 || ALU_jump !== 1'b0) begin
            n_err++; $display("FAIL flush_clear: got valid %b jump %b want 0 0", ALU_valid, ALU_jump);
        end
        step();
        n_vec++;
        if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard: got valid %b want 0", ALU_valid); end
    endtask

    task automatic test_rdy_hold();
        res_t o;
        res_t e;
        drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h400, 4'd2); step();
        ALU_enable = 1'b0; rdy = 1'b0;
        e = '{1'b1, 32'd12, 4'd2, 1'b0, 32'h404};
        o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL hold_setup: got %h want %h", o, e); end
        for (int i = 0; i < 3; i++) begin
            step();
            o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL hold_cycle%0d: got %h want %h", i, o, e); end
        end
        rdy = 1'b1; step();
        n_vec++;
        if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got valid %b want 0", ALU_valid); end
    endtask

    task automatic test_async_reset();
        res_t o;
        drive(OP_JAL, 32'd0, 32'd0, 32'h10, 32'h500, 4'd9); step(); ALU_enable = 1'b0;
        n_vec++;
        if (ALU_valid !== 1'b1) begin n_err++; $display("FAIL async_setup: got valid %b want 1", ALU_valid); end
        #2 rst = 1'b1;
        #1;
        o = sample(); n_vec++;
        if (o !== res_t'(0) || ALU_busy !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got %h busy %b want 0 0", o, ALU_busy);
        end
        #1 rst = 1'b0;
        step();
    endtask

`ifdef ALU_ITER_SHIFT_EN
    task automatic test_iter_shift();
        res_t o;
        res_t e;
        drive(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'h80, 4'd6); step(); ALU_enable = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_vec++;
            if (ALU_busy !== 1'b1 || ALU_valid !== 1'b0) begin
                n_err++; $display("FAIL srai_busy_edge%0d: got busy %b valid %b want 1 0", k, ALU_busy, ALU_valid);
            end
            if (k <= 3) drive(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h90, 4'd12);
            else        ALU_enable = 1'b0;
        end
        step();
        e = '{1'b1, 32'hF800_0000, 4'd6, 1'b0, 32'h84};
        o = sample(); n_vec++;
        if (o !== e || ALU_busy !== 1'b0) begin
            n_err++; $display("FAIL srai_result: got %h busy %b want %h busy 0", o, ALU_busy, e);
        end
        step();
        n_vec++;
        if (ALU_valid !== 1'b0) begin n_err++; $display("FAIL busy_dispatch_ignored: got valid %b want 0", ALU_valid); end

        drive(OP_SLLI, 32'h1234, 32'd0, 32'd0, 32'hA0, 4'd1); step(); ALU_enable = 1'b0;
        e = '{1'b1, 32'h1234, 4'd1, 1'b0, 32'hA4};
        o = sample(); n_vec++;
        if (o !== e || ALU_busy !== 1'b0) begin
            n_err++; $display("FAIL shamt0: got %h busy %b want %h busy 0", o, ALU_busy, e);
        end
    endtask

    task automatic test_iter_random(input int n);
        res_t o;
        res_t e;
        logic [5:0] op;
        logic [31:0] a, b, imm;
        int amt;
        int lat;
        for (int i = 0; i < n; i++) begin
            op = 6'(OP_SLLI + $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) op = (op == OP_SLLI) ? OP_SLL : (op == OP_SRLI) ? OP_SRL : OP_SRA;
            amt = $urandom_range(1, 31);
            a = $urandom; b = $urandom; imm = $urandom;
            b[4:0] = 5'(amt); imm[4:0] = 5'(amt);
            drive(op, a, b, imm, 32'h600, 4'($urandom));
            e = model(op, a, b, imm, 32'h600, robid_to_ALU);
            step(); ALU_enable = 1'b0;
            lat = 0;
            while (ALU_valid !== 1'b1 && lat < 40) begin step(); lat++; end
            o = sample(); n_vec++;
            if (lat != amt + 1 || o !== e) begin
                n_err++; $display("FAIL iter_shift_op%0d_amt%0d: got latency %0d value %h want latency %0d value %h",
                                  op, amt, lat, o, amt + 1, e);
            end
            step();
        end
    endtask

    task automatic test_mid_shift_flush();
        res_t o;
        res_t e;
        int seen;
        drive(OP_SLL, 32'd1, 32'd10, 32'd0, 32'h700, 4'd9); step(); ALU_enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        n_vec++;
        if (ALU_busy !== 1'b1) begin n_err++; $display("FAIL midflush_busy: got %b want 1", ALU_busy); end
        drive(OP_ADD, 32'd8, 32'd8, 32'd0, 32'h710, 4'd10);
        pred_fail_flag = 1'b1; step(); pred_fail_flag = 1'b0; ALU_enable = 1'b0;
        n_vec++;
        if (ALU_busy !== 1'b0 || ALU_valid !== 1'b0) begin
            n_err++; $display("FAIL midflush_clear: got busy %b valid %b want 0 0", ALU_busy, ALU_valid);
        end
        drive(OP_ADD, 32'd3, 32'd4, 32'd0, 32'h720, 4'd1); step(); ALU_enable = 1'b0;
        e = '{1'b1, 32'd7, 4'd1, 1'b0, 32'h724};
        o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL midflush_add: got %h want %h", o, e); end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (ALU_valid === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL midflush_ghost: got %0d valid cycles want 0", seen); end
    endtask
`else
    task automatic test_barrel_shift();
        res_t o;
        res_t e;
        drive(OP_SRAI, 32'h8000_0000, 32'd0, 32'd4, 32'h80, 4'd6); step(); ALU_enable = 1'b0;
        e = '{1'b1, 32'hF800_0000, 4'd6, 1'b0, 32'h84};
        o = sample(); n_vec++;
        if (o !== e || ALU_busy !== 1'b0) begin
            n_err++; $display("FAIL barrel_srai: got %h busy %b want %h busy 0", o, ALU_busy, e);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; rdy = 1'b1; pred_fail_flag = 1'b0; ALU_enable = 1'b0;
        op_to_ALU = '0; vj_to_ALU = '0; vk_to_ALU = '0; imm_to_ALU = '0;
        curpc_to_ALU = '0; robid_to_ALU = '0;
        test_reset();
        test_directed();
        test_random(400);
        test_flush();
        test_rdy_hold();
`ifdef ALU_ITER_SHIFT_EN
        test_iter_shift();
        test_iter_random(8);
        test_mid_shift_flush();
`else
        test_barrel_shift();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution unit at the far end of the reservation-station dispatch port. Accepts one ready RV32I integer operation per cycle from the RS (`ALU_enable` plus operands), computes the result, and for control-flow ops also computes the branch decision and target. Drives the common result broadcast (`ALU_valid`/`ALU_value`/`ALU_robid`) consumed by the RS, the ROB and the store/load buffer for operand wake-up. Sits between the RS and the ROB.

## Interface
Parameters: none. Op encodings `OP_*`, `OP_SIZE_LOG` and `ROB_SIZE_LOG` come from `utils.v`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rdy` in 1: global ready; low freezes all state.
- `pred_fail_flag` in 1: mispredict flush; synchronous.
- `ALU_enable` in 1: dispatch strobe from RS.
- `op_to_ALU` in `OP_SIZE_LOG`: operation.
- `vj_to_ALU` in 32: rs1 value.
- `vk_to_ALU` in 32: rs2 value.
- `imm_to_ALU` in 32: sign-extended immediate.
- `robid_to_ALU` in `ROB_SIZE_LOG`: destination ROB tag.
- `curpc_to_ALU` in 32: instruction PC.
- `ALU_valid` out 1: result broadcast valid.
- `ALU_value` out 32: rd value.
- `ALU_robid` out `ROB_SIZE_LOG`: tag of result.
- `ALU_jump` out 1: control transfer taken (branches, JAL, JALR).
- `ALU_target_pc` out 32: taken target, or `curpc+4` when not taken.
- `ALU_busy` out 1: no dispatch accepted this cycle.

## Operation
- Reset: all outputs 0, internal shift FSM in IDLE.
- Accept when `rdy && ALU_enable && !ALU_busy && !pred_fail_flag`. A dispatch while busy is ignored.
- Results, all mod 2^32:
  - LUI: imm.
  - AUIPC: pc+imm.
  - ADD/ADDI: vj+vk or vj+imm.
  - SUB: vj−vk.
  - SLT/SLTI signed, SLTU/SLTIU unsigned: 0 or 1.
  - XOR/OR/AND and their I-forms: bitwise.
  - SLL/SRL/SRA and their I-forms: shamt = low 5 bits of vk or imm; SRA fills with sign.
  - JAL: value pc+4, target pc+imm.
  - JALR: value pc+4, target (vj+imm) & ~1.
  - BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned: value 0, jump per compare, target pc+imm if taken else pc+4.
- Non-jump ops: `ALU_jump`=0, `ALU_target_pc`=pc+4.
- Load/store/unknown ops: accepted and dropped, no `ALU_valid`.
- Shift FSM (macro only), states:
  - IDLE → SHIFT on accepting a shift op with shamt≠0.
  - SHIFT: count shamt, shift 1 bit per cycle.
  - SHIFT → DONE when count reaches 0; DONE pulses the result and returns to IDLE.

## Timing
- Non-iterative ops: 1-cycle latency. Accept at edge N; `ALU_valid`=1 with results for exactly the cycle after edge N. Back-to-back dispatch each cycle gives back-to-back results.
- `ALU_valid` deasserts at the next accepted edge with no new result.
- `rdy` low: all registers hold, including a pending `ALU_valid`, which stays high until the first edge with `rdy`=1.
- `pred_fail_flag` at an edge with `rdy`=1: `ALU_valid`←0, `ALU_jump`←0, FSM→IDLE, busy←0. A simultaneous dispatch is discarded (flush wins).
- `rst` asserted at any time, including mid-shift: immediate return to reset values, without waiting for a clock edge.

## Configuration
- `ALU_ITER_SHIFT_EN` defined:
  - Shifts use the iterative FSM. Latency is 1+shamt cycles: `ALU_valid` appears shamt+1 edges after accept.
  - `ALU_busy`=1 from the edge after accept until the edge the result is registered.
  - shamt=0 behaves as a 1-cycle op.
- Undefined: barrel shifter, every op 1 cycle, `ALU_busy` tied 0.

## Test plan
- SUB, vj=0, vk=1, robid=5: next cycle `ALU_valid`=1, value 0xFFFFFFFF, robid 5, jump 0, target pc+4.
- BLT, vj=0xFFFFFFFF, vk=1, pc=0x100, imm=0x20: jump=1, target 0x120. Same inputs as BLTU: jump 0, target 0x104.
- JALR, vj=0x1003, imm=0, pc=0x40: value 0x44, target 0x1002, jump 1.
- `ALU_ITER_SHIFT_EN`, SRAI vj=0x80000000, shamt=4:
  - busy for 4 cycles; valid on the 5th edge after accept with value 0xF8000000.
  - A dispatch issued while busy produces no result.
- Mid-shift `pred_fail_flag` pulse: no `ALU_valid` ever appears for that tag; busy 0 on the next cycle; a new ADD is accepted immediately.
- ADD result pending, then `rdy` low 3 cycles: `ALU_valid`/value held for all 3 cycles, then clear one edge after `rdy` returns; async `rst` pulse mid-cycle clears all outputs before the next edge.
